rv32_irq_evt_gen: RTL and testbench
===================================

// Module: rv32_irq_evt_gen
// PURPOSE
//  Source of the irq_evt_t event consumed by the next-PC logic.
//  - Latches external interrupt lines and arbitrates them.
//  - On trap entry, drives a redirect to the trap vector.
//  - Holds mepc and presents it on csr_irq_evt.data so MRET can return.
//  - Owns the machine-mode trap CSRs: mstatus MIE/MPIE, mie, mip, mtvec, mepc, mcause.
//  - Sits beside the CSR file, between the decode/exec stage and the PC stage.
// PARAMETERS
//  NUM_IRQ  default 4  external interrupt lines, 1..16; line i maps to cause code 16+i.
// PORTS
//  clk              in   1        core clock
//  rst_n            in   1        asynchronous active-low reset
//  irq_i            in   NUM_IRQ  level interrupt requests, already synchronous to clk
//  instr_valid      in   1        the opcode and PC below are a retiring instruction
//  rv32_instr_opcode in  enum     rv32_opcode_enum_t of the retiring instruction
//  rv32_cur_pc      in   32       PC of the retiring instruction
//  csr_we           in   1        CSR write strobe
//  csr_addr         in   12       CSR address (read and write)
//  csr_wdata        in   32       CSR write data
//  csr_rdata        out  32       combinational read of csr_addr; 0 if unmapped
//  csr_irq_evt      out  irq_evt_t  {valid, data}: trap redirect pulse / trap or return target
//  irq_taken        out  NUM_IRQ  one-hot, high in the entry cycle for the line taken
// BEHAVIOUR
//  Reset values
//   - All CSRs 0; mstatus.MIE=0, MPIE=0.
//   - FSM = RUN; csr_irq_evt = '0; irq_taken = 0.
//  CSR map
//   - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
//   - mie 0x304: bits[16+:NUM_IRQ].
//   - mtvec 0x305: bit0 = vectored mode, bit1 reads 0.
//   - mepc 0x341: bits[1:0] forced to 0.
//   - mcause 0x342.
//   - mip 0x344: read-only; writes are ignored.
//  mip
//   - mip[16+i] = irq_i[i] registered (1-cycle delay).
//   - The line is level-held by the source; this block does not clear it.
//  Eligibility
//   - pend = mip & mie & {32{MIE}}, valid only in the RUN state.
//   - Winner = lowest-indexed eligible line.
//  FSM states: RUN, ENTER, HANDLER
//   - RUN -> ENTER: when a winner exists AND instr_valid AND the opcode is not MRET.
//     The instruction at rv32_cur_pc is treated as not executed.
//   - RUN -> ENTER is evaluated before any csr_we in the same cycle; a CSR write that
//     cycle is still committed.
//   - ENTER (exactly 1 cycle):
//     * Pulse csr_irq_evt.valid=1.
//     * data = mtvec[0] ? {mtvec[31:2],2'b0} + 4*(16+i) : {mtvec[31:2],2'b0}.
//     * Assert irq_taken[i].
//     * mepc <= captured PC; mcause <= {1'b1, 31'(16+i)}; MPIE <= MIE; MIE <= 0.
//     * ENTER -> HANDLER unconditionally.
//   - HANDLER:
//     * Interrupts are masked.
//     * instr_valid with opcode RV32_MRET: MIE <= MPIE; MPIE <= 1; -> RUN next cycle.
//     * The MRET redirect itself is taken by the PC stage from data; valid stays 0.
//   - MRET seen while in RUN: same MIE/MPIE update; state unchanged.
//  Output data
//   - csr_irq_evt.data = mepc whenever valid=0, so MRET always reads the return target.
//  Latency
//   - irq_i rise -> mip: 1 cycle.
//   - mip -> ENTER: next valid retiring instruction.
//  Simultaneous events
//   - A csr_we to mepc/mcause/mstatus in the ENTER cycle loses to the hardware update.
//   - A csr_we to mie while in RUN takes effect the next cycle.
//  Reset mid-operation
//   - Asynchronous return to RUN with every CSR cleared.
//   - A valid pulse in progress drops immediately.
//  Arithmetic
//   - Vector address computed mod 2^32; wrap is allowed and not flagged.
// TESTING
//  1 Reset:
//    - Assert rst_n=0 mid-ENTER.
//    - Required: valid drops the same cycle; all CSRs read 0 and state = RUN after release.
//  2 Direct mode:
//    - mtvec=0x100, mie[16]=1, MIE=1; irq_i[0]=1; instr_valid with pc=0x40.
//    - Required: one valid pulse, data=0x100; then mepc=0x40, mcause=0x80000010, MIE=0, MPIE=1.
//  3 Vectored mode and priority:
//    - mtvec=0x201, irq_i=4'b1100, both lines enabled.
//    - Required: line 2 taken, data=0x200+4*18=0x248, irq_taken=4'b0100.
//  4 Masking:
//    - MIE=0, or mie bit clear, or state HANDLER, with irq_i held high.
//    - Required: no valid pulse; mip still reads the bit set.
//  5 MRET return:
//    - In HANDLER, instr_valid with RV32_MRET.
//    - Required: data=mepc (0x40), valid=0, MIE=1, state RUN.
//    - With irq_i still high, a new entry occurs on the next valid instruction.
//  6 Write collision:
//    - csr_we to mepc=0xDEAD in the ENTER cycle.
//    - Required: mepc holds the captured PC, not 0xDEAD.

Source files
------------

// File: rtl/rv32_irq_evt_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rv32_irq_evt_gen_pkg / rv32_irq_evt_gen_if                      |
// | Shared types (retiring-opcode enum, irq_evt_t) and the bus interface     |
// | between the decode/exec stage, the PC stage and rv32_irq_evt_gen.        |
// |   instr_valid, rv32_instr_opcode, rv32_cur_pc : retiring instruction     |
// |   csr_we, csr_addr, csr_wdata, csr_rdata      : CSR access port          |
// |   csr_irq_evt                                 : {valid, data} to next-PC |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

package rv32_irq_evt_gen_pkg;

  typedef enum logic [2:0] {
    RV32_OP_NOP    = 3'd0,
    RV32_OP_ALU    = 3'd1,
    RV32_OP_LOAD   = 3'd2,
    RV32_OP_STORE  = 3'd3,
    RV32_OP_BRANCH = 3'd4,
    RV32_OP_JUMP   = 3'd5,
    RV32_OP_SYSTEM = 3'd6,
    RV32_MRET      = 3'd7
  } rv32_opcode_enum_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } irq_evt_t;

endpackage

interface rv32_irq_evt_gen_if;
  import rv32_irq_evt_gen_pkg::*;

  logic              instr_valid;
  rv32_opcode_enum_t rv32_instr_opcode;
  logic [31:0]       rv32_cur_pc;
  logic              csr_we;
  logic [11:0]       csr_addr;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  irq_evt_t          csr_irq_evt;

  modport master (
    output instr_valid, rv32_instr_opcode, rv32_cur_pc,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_irq_evt
  );

  modport slave (
    input  instr_valid, rv32_instr_opcode, rv32_cur_pc,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_irq_evt
  );

endinterface
`default_nettype wire

// File: rtl/rv32_irq_evt_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rv32_irq_evt_gen                                                |
// | Machine-mode interrupt/trap event source for the next-PC logic. Latches  |
// | external interrupt lines into mip, arbitrates them (lowest index wins),  |
// | redirects to the trap vector on entry and presents mepc for MRET.        |
// | Ports:                                                                   |
// |   clk, rst_n   : clock, asynchronous active-low reset                    |
// |   irq_i        : level interrupt requests (synchronous to clk)           |
// |   bus (slave)  : retiring instruction, CSR port, csr_irq_evt output      |
// |   irq_taken    : one-hot line taken, high during the entry cycle         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module rv32_irq_evt_gen
  import rv32_irq_evt_gen_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_i,
  rv32_irq_evt_gen_if.slave   bus,
  output logic [NUM_IRQ-1:0]  irq_taken
);

  localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] c_ADDR_MIE     = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] c_ADDR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_IRQ-1:0] r_mip;
  logic [NUM_IRQ-1:0] r_mie;
  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [29:0]        r_mtvec_base;
  logic               r_mtvec_mode;
  logic [29:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [29:0]        r_cap_pc;
  logic [3:0]         r_cap_idx;

  logic [NUM_IRQ-1:0] w_pend;
  logic               w_win_any;
  logic [3:0]         w_win_idx;
  logic               w_is_mret;
  logic               w_take;
  logic [31:0]        w_vec_base;
  logic [31:0]        w_vec_off;
  logic               w_evt_valid;
  logic [31:0]       w_evt_data;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // PC is word aligned; its low bits carry no information here.
  assign w_unused = ^bus.rv32_cur_pc[1:0];

  assign w_is_mret = bus.instr_valid && (bus.rv32_instr_opcode == RV32_MRET);

  // Eligibility is only meaningful in RUN; ENTER/HANDLER mask everything.
  assign w_pend = (r_state == ST_RUN && r_mstatus_mie) ? (r_mip & r_mie) : '0;

  // Lowest index wins: scan downward so the last hit is the lowest line.
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_win_any = 1'b1;
        w_win_idx = 4'(i);
      end
    end
  end

  assign w_take = w_win_any && bus.instr_valid && !w_is_mret;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_take) w_state_nxt = ST_ENTER;
      ST_ENTER:   w_state_nxt = ST_HANDLER;
      ST_HANDLER: if (w_is_mret) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Cause code 16+i fits in 5 bits as {1'b1, i}; vector offset is 4*(16+i).
  assign w_vec_base  = {r_mtvec_base, 2'b00};
  assign w_vec_off   = {25'd0, 1'b1, r_cap_idx, 2'b00};
  assign w_evt_valid = (r_state == ST_ENTER);
  assign w_evt_data  = w_evt_valid
                     ? (r_mtvec_mode ? (w_vec_base + w_vec_off) : w_vec_base)
                     : {r_mepc, 2'b00};

  assign bus.csr_irq_evt = {w_evt_valid, w_evt_data};
  assign irq_taken = w_evt_valid ? (NUM_IRQ'(1) << r_cap_idx) : '0;

  // CSR state. Software writes are applied first; the hardware updates below
  // are later non-blocking assignments, so they win on any collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mip          <= '0;
      r_mie          <= '0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mtvec_base   <= '0;
      r_mtvec_mode   <= 1'b0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_cap_pc       <= '0;
      r_cap_idx      <= '0;
    end else begin
      r_mip <= irq_i;

      if (bus.csr_we) begin
        case (bus.csr_addr)
          c_ADDR_MSTATUS: begin
            r_mstatus_mie  <= bus.csr_wdata[3];
            r_mstatus_mpie <= bus.csr_wdata[7];
          end
          c_ADDR_MIE:    r_mie <= bus.csr_wdata[16 +: NUM_IRQ];
          c_ADDR_MTVEC: begin
            r_mtvec_base <= bus.csr_wdata[31:2];
            r_mtvec_mode <= bus.csr_wdata[0];
          end
          c_ADDR_MEPC:   r_mepc   <= bus.csr_wdata[31:2];
          c_ADDR_MCAUSE: r_mcause <= bus.csr_wdata;
          default: ;
        endcase
      end

      // The interrupted instruction is not executed; its PC becomes mepc.
      if (w_take) begin
        r_cap_pc  <= bus.rv32_cur_pc[31:2];
        r_cap_idx <= w_win_idx;
      end

      if (r_state == ST_ENTER) begin
        r_mepc         <= r_cap_pc;
        r_mcause       <= {1'b1, 26'd0, 1'b1, r_cap_idx};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_is_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.csr_addr)
      c_ADDR_MSTATUS: begin
        w_rdata[3] = r_mstatus_mie;
        w_rdata[7] = r_mstatus_mpie;
      end
      c_ADDR_MIE:    w_rdata[16 +: NUM_IRQ] = r_mie;
      c_ADDR_MTVEC:  w_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
      c_ADDR_MEPC:   w_rdata = {r_mepc, 2'b00};
      c_ADDR_MCAUSE: w_rdata = r_mcause;
      c_ADDR_MIP:    w_rdata[16 +: NUM_IRQ] = r_mip;
      default:       w_rdata = '0;
    endcase
  end

  assign bus.csr_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32_irq_evt_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_rv32_irq_evt_gen                                             |
// | Directed self-checking bench for rv32_irq_evt_gen (NUM_IRQ = 4).         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module tb_rv32_irq_evt_gen;
  import rv32_irq_evt_gen_pkg::*;

  localparam int NUM_IRQ = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_taken;

  int errors = 0;
  int checks = 0;

  rv32_irq_evt_gen_if bus ();

  rv32_irq_evt_gen #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq_i),
    .bus       (bus),
    .irq_taken (irq_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    tick();
    bus.csr_we    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  task automatic retire(input logic [31:0] pc, input rv32_opcode_enum_t op);
    bus.instr_valid       = 1'b1;
    bus.rv32_cur_pc       = pc;
    bus.rv32_instr_opcode = op;
    tick();
    bus.instr_valid       = 1'b0;
  endtask

  initial begin
    rst_n                 = 1'b0;
    irq_i                 = '0;
    bus.instr_valid       = 1'b0;
    bus.rv32_instr_opcode = RV32_OP_NOP;
    bus.rv32_cur_pc       = '0;
    bus.csr_we            = 1'b0;
    bus.csr_addr          = '0;
    bus.csr_wdata         = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    check("rst_data", bus.csr_irq_evt.data, 32'd0);
    check("rst_taken", {28'd0, irq_taken}, 32'd0);
    rd_check("rst_mstatus", 12'h300, 32'd0);
    rd_check("rst_mie", 12'h304, 32'd0);
    rd_check("rst_mtvec", 12'h305, 32'd0);
    rd_check("rst_mepc", 12'h341, 32'd0);
    rd_check("rst_mcause", 12'h342, 32'd0);
    rd_check("rst_mip", 12'h344, 32'd0);
    rd_check("unmapped", 12'h7C0, 32'd0);

    // Direct mode entry
    wr(12'h305, 32'h0000_0100);
    wr(12'h304, 32'h0001_0000);
    wr(12'h300, 32'h0000_0008);
    irq_i = 4'b0001;
    tick();
    rd_check("mip_set", 12'h344, 32'h0001_0000);
    check("idle_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    retire(32'h0000_0040, RV32_OP_ALU);
    check("dir_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    check("dir_data", bus.csr_irq_evt.data, 32'h0000_0100);
    check("dir_taken", {28'd0, irq_taken}, 32'h1);
    // Software write to mepc in the entry cycle must lose
    wr(12'h341, 32'h0000_DEAD);
    check("hnd_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    check("hnd_data_mepc", bus.csr_irq_evt.data, 32'h0000_0040);
    rd_check("dir_mepc", 12'h341, 32'h0000_0040);
    rd_check("dir_mcause", 12'h342, 32'h8000_0010);
    rd_check("dir_mstatus", 12'h300, 32'h0000_0080);

    // Masked while in the handler, irq still high
    retire(32'h0000_0100, RV32_OP_ALU);
    check("hnd_mask_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    check("hnd_mask_taken", {28'd0, irq_taken}, 32'd0);
    rd_check("hnd_mip", 12'h344, 32'h0001_0000);
    wr(12'h341, 32'h0000_0043);
    rd_check("mepc_align", 12'h341, 32'h0000_0040);
    wr(12'h344, 32'hFFFF_FFFF);
    rd_check("mip_ro", 12'h344, 32'h0001_0000);

    // MRET returns to RUN with MIE restored
    retire(32'h0000_0104, RV32_MRET);
    check("mret_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    check("mret_data", bus.csr_irq_evt.data, 32'h0000_0040);
    rd_check("mret_mstatus", 12'h300, 32'h0000_0088);
    retire(32'h0000_0080, RV32_OP_ALU);
    check("reent_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    check("reent_data", bus.csr_irq_evt.data, 32'h0000_0100);
    tick();
    rd_check("reent_mepc", 12'h341, 32'h0000_0080);

    // Reset asserted in the middle of an entry cycle
    retire(32'h0000_0084, RV32_MRET);
    retire(32'h0000_0088, RV32_OP_ALU);
    check("pre_rst_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    check("rst_mid_taken", {28'd0, irq_taken}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rd_check("rst2_mstatus", 12'h300, 32'd0);
    rd_check("rst2_mie", 12'h304, 32'd0);
    rd_check("rst2_mtvec", 12'h305, 32'd0);
    rd_check("rst2_mepc", 12'h341, 32'd0);
    rd_check("rst2_mcause", 12'h342, 32'd0);
    // Back in RUN: an enabled line enters on the next instruction
    wr(12'h304, 32'h0001_0000);
    wr(12'h300, 32'h0000_0008);
    retire(32'h0000_0010, RV32_OP_ALU);
    check("rst2_entry_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    check("rst2_entry_data", bus.csr_irq_evt.data, 32'd0);
    tick();

    // Vectored mode and priority: lines 2 and 3 pending
    irq_i = 4'b1100;
    wr(12'h305, 32'h0000_0201);
    rd_check("vec_mtvec", 12'h305, 32'h0000_0201);
    wr(12'h304, 32'h000C_0000);
    retire(32'h0000_0014, RV32_MRET);
    retire(32'h0000_0104, RV32_OP_ALU);
    check("vec_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    check("vec_data", bus.csr_irq_evt.data, 32'h0000_0248);
    check("vec_taken", {28'd0, irq_taken}, 32'h4);
    tick();
    rd_check("vec_mcause", 12'h342, 32'h8000_0012);
    rd_check("vec_mepc", 12'h341, 32'h0000_0104);

    // Masking by MIE=0
    retire(32'h0000_0108, RV32_MRET);
    wr(12'h300, 32'h0000_0000);
    retire(32'h0000_0108, RV32_OP_ALU);
    check("mie0_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    rd_check("mie0_mip", 12'h344, 32'h000C_0000);
    // Masking by cleared mie bits
    wr(12'h304, 32'h0003_0000);
    wr(12'h300, 32'h0000_0008);
    retire(32'h0000_010C, RV32_OP_ALU);
    check("miebit_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd0);
    // Enabling line 3 only takes effect for the following instruction
    wr(12'h304, 32'h0008_0000);
    retire(32'h0000_0110, RV32_OP_ALU);
    check("l3_valid", {31'd0, bus.csr_irq_evt.valid}, 32'd1);
    check("l3_data", bus.csr_irq_evt.data, 32'h0000_024C);
    check("l3_taken", {28'd0, irq_taken}, 32'h8);
    tick();
    rd_check("l3_mcause", 12'h342, 32'h8000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
